avalon_mm_arbiter: RTL and testbench
====================================

# avalon_mm_arbiter

Shares one Avalon-MM slave port between `NUM_MASTERS` Avalon-MM masters on the FPGA fabric. Arbitration is round-robin and burst-locked. Each transaction is one write burst or one read command. Read responses are routed back to the issuing master through an in-order tracking FIFO. The block sits between the master BFMs or DMA engines and the shared slave, on the same 12-bit address / 32-bit data bus used by the rest of the design.

## Interface
- `NUM_MASTERS`, 2: number of requesters, 2 to 4.
- `ADDR_W`, 12: address width.
- `DATA_W`, 32: data width, 4 symbols of 8 bits.
- `BURST_W`, 4: burstcount width. Maximum burst is 8.
- `MAX_PENDING`, 4: maximum outstanding read commands. Must be a power of 2.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous reset, active-high.
- `m_address` in NUM_MASTERS*ADDR_W: per-master address, packed with master 0 in the LSBs.
- `m_read`, `m_write` in NUM_MASTERS: per-master command strobes.
- `m_writedata` in NUM_MASTERS*DATA_W: per-master write data.
- `m_byteenable` in NUM_MASTERS*4: per-master byte enables.
- `m_burstcount` in NUM_MASTERS*BURST_W: per-master burst length.
- `m_waitrequest` out NUM_MASTERS: per-master backpressure.
- `m_readdata` out DATA_W: read data, broadcast to all masters.
- `m_readdatavalid` out NUM_MASTERS: per-master read-data valid, one-hot.
- `s_address`, `s_read`, `s_write`, `s_writedata`, `s_byteenable`, `s_burstcount` out: slave command signals, forwarded from the granted master.
- `s_waitrequest` in 1: slave backpressure.
- `s_readdata` in DATA_W, `s_readdatavalid` in 1: slave read response.

## Operation
- FSM states:
  - IDLE: choose a requester, register grant index `gnt`, go to LOCKED.
  - LOCKED: forward the granted master's command to the slave.
- Requester selection in IDLE:
  - A master is eligible if `m_write`=1, or if `m_read`=1 and the FIFO is not full.
  - The eligible master at or after `rr_ptr`, scanning upward with wrap, wins.
- In LOCKED:
  - `s_*` command signals equal the granted master's signals, combinationally.
  - `m_waitrequest[gnt]` = `s_waitrequest`.
  - All other `m_waitrequest` bits = 1.
- A beat is accepted when (`s_read` or `s_write`) and !`s_waitrequest`.
- Write burst:
  - A beat counter is cleared on grant and increments on each accepted write beat.
  - The transaction ends on the beat where count+1 == burstcount.
  - Burstcount 0 is treated as 1.
- Read:
  - The transaction ends on command acceptance.
  - {`gnt`, burstcount} is pushed to the FIFO in the same cycle.
- On transaction end: next state IDLE, `rr_ptr` = `gnt`+1 mod NUM_MASTERS.
- If the granted master drops its request while LOCKED, the grant is held. The slave sees `s_read`/`s_write` = 0 and the master is not re-arbitrated.
- Response routing:
  - `m_readdatavalid[fifo_head.id]` = `s_readdatavalid`.
  - A remaining-beat counter is loaded from the head entry and decrements on each valid beat.
  - The FIFO pops on the last beat.
- `s_readdatavalid` with an empty FIFO is dropped.
- A push and a pop in the same cycle are both performed.

## Timing
- Arbitration latency: a request at edge N is granted at edge N+1, and the slave sees the command during cycle N+1.
- There is one IDLE bubble between consecutive transactions.
- `m_readdata` and `m_readdatavalid` are combinational from the slave, with zero added latency.
- Reset values:
  - State IDLE, `rr_ptr`=0.
  - FIFO empty, counters 0.
  - `s_read`=`s_write`=0.
  - All `m_waitrequest`=1 and all `m_readdatavalid`=0.
  - `s_address`, `s_writedata` and `s_byteenable` are 0.
- Reset mid-burst aborts the burst and flushes the FIFO. Read data arriving after reset is dropped.

## Configuration
- `AVMM_ARB_FIXED_PRIORITY_EN`:
  - Defined: in IDLE the lowest-index eligible master always wins, and `rr_ptr` is held at 0.
  - Undefined: round-robin as described above.

## Structure
- Package `avmm_arb_pkg` holds:
  - constants `MAX_BURST`=8 and `NUM_SYMBOLS`=4;
  - enum `arb_state_t` {IDLE, LOCKED};
  - struct `rsp_route_t` {id, burstcount}.
- Sub-module `avmm_rsp_route_fifo` is a synchronous FIFO of `rsp_route_t`, `MAX_PENDING` deep, with full/empty flags.

## Test plan
- M0 and M1 both request single writes to 0x010 and 0x020 at the same edge, from reset → M0 is granted first, then M1 after one bubble cycle. Slave sees 0x010 then 0x020.
- M0 issues a write burst of 4 while M1 requests, with `s_waitrequest` high for 2 cycles on beat 2 → all 4 M0 beats complete before M1 is granted.
- M1 reads 0x004 with burst 3, then M0 reads 0x008 with burst 1. Slave returns AA, BB, CC, DD → `m_readdatavalid[1]` pulses 3 times, then `m_readdatavalid[0]` pulses once on DD.
- 4 reads are outstanding with no response → the FIFO is full, a 5th read stays waitrequested while a concurrent write is granted. The 5th read is granted after one response completes.
- Assert `reset` during beat 2 of a 4-beat write → `s_write`=0 and all `m_waitrequest`=1 immediately. State returns to IDLE.
- With `AVMM_ARB_FIXED_PRIORITY_EN` defined, M0 requests continuously alongside M1 → M1 is never granted until M0 deasserts.

Source files
------------

// File: rtl/avmm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : avmm_arb_pkg
// Desc   : Shared types and constants for the Avalon-MM arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package avmm_arb_pkg;

    localparam int MAX_BURST   = 8;
    localparam int NUM_SYMBOLS = 4;
    localparam int ID_W        = 2;
    localparam int BC_W        = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [BC_W-1:0] burstcount;
    } rsp_route_t;

endpackage
`default_nettype wire

// File: rtl/avmm_rsp_route_fifo.sv
`default_nettype none
// ============================================================================
// Module : avmm_rsp_route_fifo
// Desc   : Synchronous FIFO of read-response routes, DEPTH entries (power of 2).
// Rev    : 1.0 - initial release
// ============================================================================
module avmm_rsp_route_fifo
    import avmm_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  rsp_route_t push_data,
    input  logic       pop,
    output rsp_route_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    rsp_route_t       r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign head   = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/avalon_mm_arbiter.sv
`default_nettype none
// ============================================================================
// Module : avalon_mm_arbiter
// Desc   : Round-robin, burst-locked sharing of one Avalon-MM slave among
//          NUM_MASTERS masters. Option macro: AVMM_ARB_FIXED_PRIORITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module avalon_mm_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int BURST_W     = 4,
    parameter int MAX_PENDING = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0]      m_address,
    input  logic [NUM_MASTERS-1:0]             m_read,
    input  logic [NUM_MASTERS-1:0]             m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0]      m_writedata,
    input  logic [NUM_MASTERS*NUM_SYMBOLS-1:0] m_byteenable,
    input  logic [NUM_MASTERS*BURST_W-1:0]     m_burstcount,
    output logic [NUM_MASTERS-1:0]             m_waitrequest,
    output logic [DATA_W-1:0]                  m_readdata,
    output logic [NUM_MASTERS-1:0]             m_readdatavalid,
    output logic [ADDR_W-1:0]                  s_address,
    output logic                               s_read,
    output logic                               s_write,
    output logic [DATA_W-1:0]                  s_writedata,
    output logic [NUM_SYMBOLS-1:0]             s_byteenable,
    output logic [BURST_W-1:0]                 s_burstcount,
    input  logic                               s_waitrequest,
    input  logic [DATA_W-1:0]                  s_readdata,
    input  logic                               s_readdatavalid
);

    localparam int GNT_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [ADDR_W-1:0]        w_addr  [NUM_MASTERS];
    logic [DATA_W-1:0]        w_wdata [NUM_MASTERS];
    logic [NUM_SYMBOLS-1:0]   w_be    [NUM_MASTERS];
    logic [BURST_W-1:0]       w_bc    [NUM_MASTERS];

    arb_state_t               r_state;
    logic [GNT_W-1:0]         r_gnt;
    logic [GNT_W-1:0]         r_rr_ptr;
    logic [BURST_W-1:0]       r_beat_cnt;
    logic [BURST_W-1:0]       r_rsp_cnt;

    logic [NUM_MASTERS-1:0]   w_elig;
    logic [2*NUM_MASTERS-1:0] w_elig_rot;
    logic                     w_any;
    logic [GNT_W:0]           w_sum;
    logic [GNT_W-1:0]         w_sel;
    logic [GNT_W-1:0]         w_rr_next;
    logic [BURST_W-1:0]       w_eff_bc;
    logic                     w_accept;
    logic                     w_txn_end;
    logic                     w_push;
    rsp_route_t               w_push_data;
    rsp_route_t               w_head;
    logic [BURST_W-1:0]       w_head_bc;
    logic                     w_rsp_beat;
    logic                     w_pop;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign w_addr[g]  = m_address[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = m_writedata[g*DATA_W +: DATA_W];
        assign w_be[g]    = m_byteenable[g*NUM_SYMBOLS +: NUM_SYMBOLS];
        assign w_bc[g]    = m_burstcount[g*BURST_W +: BURST_W];
        assign m_readdatavalid[g] = s_readdatavalid & ~w_fifo_empty &
                                    (w_head.id == ID_W'(g));
    end

    // Reads are only eligible while a route slot is free for their response.
    assign w_elig     = m_write | (m_read & {NUM_MASTERS{~w_fifo_full}});
    assign w_elig_rot = {w_elig, w_elig} >> r_rr_ptr;

    always_comb begin
        w_any = 1'b0;
        w_sum = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (w_elig_rot[k]) begin
                w_any = 1'b1;
                w_sum = {1'b0, r_rr_ptr} + (GNT_W+1)'(k);
            end
        end
        w_sel = (w_sum >= (GNT_W+1)'(NUM_MASTERS)) ?
                GNT_W'(w_sum - (GNT_W+1)'(NUM_MASTERS)) : GNT_W'(w_sum);
    end

`ifdef AVMM_ARB_FIXED_PRIORITY_EN
    assign w_rr_next = '0;
`else
    assign w_rr_next = (r_gnt == GNT_W'(NUM_MASTERS - 1)) ? '0 : r_gnt + GNT_W'(1);
`endif

    always_comb begin
        s_address     = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_writedata   = '0;
        s_byteenable  = '0;
        s_burstcount  = '0;
        m_waitrequest = '1;
        if (r_state == LOCKED) begin
            s_address            = w_addr[r_gnt];
            s_read               = m_read[r_gnt];
            s_write              = m_write[r_gnt];
            s_writedata          = w_wdata[r_gnt];
            s_byteenable         = w_be[r_gnt];
            s_burstcount         = w_bc[r_gnt];
            m_waitrequest[r_gnt] = s_waitrequest;
        end
    end

    assign w_eff_bc  = (w_bc[r_gnt] == '0) ? BURST_W'(1) : w_bc[r_gnt];
    assign w_accept  = (s_read | s_write) & ~s_waitrequest;
    assign w_txn_end = w_accept & (s_write ? ((r_beat_cnt + BURST_W'(1)) == w_eff_bc) : 1'b1);
    assign w_push    = w_accept & s_read & ~s_write;
    assign w_push_data = '{id: ID_W'(r_gnt), burstcount: BC_W'(w_bc[r_gnt])};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt      <= w_sel;
                        r_beat_cnt <= '0;
                        r_state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_accept && s_write) r_beat_cnt <= r_beat_cnt + BURST_W'(1);
                    if (w_txn_end) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_rr_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Beats delivered so far for the head route; a burstcount of 0 means 1.
    assign m_readdata = s_readdata;
    assign w_head_bc  = (w_head.burstcount == '0) ? BURST_W'(1) : BURST_W'(w_head.burstcount);
    assign w_rsp_beat = s_readdatavalid & ~w_fifo_empty;
    assign w_pop      = w_rsp_beat & ((r_rsp_cnt + BURST_W'(1)) == w_head_bc);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)           r_rsp_cnt <= '0;
        else if (w_pop)      r_rsp_cnt <= '0;
        else if (w_rsp_beat) r_rsp_cnt <= r_rsp_cnt + BURST_W'(1);
    end

    avmm_rsp_route_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_avalon_mm_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_avalon_mm_arbiter
// Desc   : Directed bench with a transaction-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_avalon_mm_arbiter;

    localparam int N  = 2;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MP = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N*AW-1:0]   m_address;
    logic [N-1:0]      m_read;
    logic [N-1:0]      m_write;
    logic [N*DW-1:0]   m_writedata;
    logic [N*4-1:0]    m_byteenable;
    logic [N*BW-1:0]   m_burstcount;
    logic [N-1:0]      m_waitrequest;
    logic [DW-1:0]     m_readdata;
    logic [N-1:0]      m_readdatavalid;
    logic [AW-1:0]     s_address;
    logic              s_read;
    logic              s_write;
    logic [DW-1:0]     s_writedata;
    logic [3:0]        s_byteenable;
    logic [BW-1:0]     s_burstcount;
    logic              s_waitrequest;
    logic [DW-1:0]     s_readdata;
    logic              s_readdatavalid;

    avalon_mm_arbiter #(
        .NUM_MASTERS (N), .ADDR_W (AW), .DATA_W (DW), .BURST_W (BW), .MAX_PENDING (MP)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_burstcount    (m_burstcount),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_burstcount    (s_burstcount),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_rd_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owner of the slave (-1 = none) and queue of pending read routes.
    typedef struct { int id; int left; } route_t;
    route_t     q[$];
    route_t     h;
    int         owner = -1;
    int         rr    = 0;
    int         beats = 0;
    int         qsz;
    int         idx;
    bit         done;

    function automatic int bc_of(input int m);
        int b;
        b = int'(m_burstcount[m*BW +: BW]);
        return (b == 0) ? 1 : b;
    endfunction

    always @(posedge clock) cyc++;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            owner = -1; rr = 0; beats = 0; q.delete();
        end else begin
            qsz = q.size();
            if (s_readdatavalid && qsz > 0) begin
                h = q[0];
                h.left--;
                if (h.left == 0) void'(q.pop_front());
                else q[0] = h;
            end
            if (owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (rr + k) % N;
                    if (owner < 0 && (m_write[idx] || (m_read[idx] && qsz < MP))) begin
                        owner = idx;
                        beats = 0;
                    end
                end
            end else if ((m_read[owner] || m_write[owner]) && !s_waitrequest) begin
                done = 1'b1;
                if (m_write[owner]) begin
                    beats++;
                    done = (beats == bc_of(owner));
                end else begin
                    q.push_back('{owner, bc_of(owner)});
                end
                if (done) begin
`ifdef AVMM_ARB_FIXED_PRIORITY_EN
                    rr = 0;
`else
                    rr = (owner + 1) % N;
`endif
                    owner = -1;
                end
            end
        end
    end

    logic [21:0]   exp_cmd;
    logic [DW-1:0] exp_wd;
    logic [N-1:0]  exp_wait;
    logic [N-1:0]  exp_rdv;
    logic [AW-1:0] wlog[$];
    logic [33:0]   rlog[$];

    always @(negedge clock) begin
        exp_cmd  = '0;
        exp_wd   = '0;
        exp_wait = '1;
        exp_rdv  = '0;
        if (owner >= 0) begin
            exp_cmd = {m_read[owner], m_write[owner], m_burstcount[owner*BW +: BW],
                       m_byteenable[owner*4 +: 4], m_address[owner*AW +: AW]};
            exp_wd  = m_writedata[owner*DW +: DW];
            exp_wait[owner] = s_waitrequest;
        end
        if (s_readdatavalid && q.size() > 0) exp_rdv[q[0].id] = 1'b1;
        chk("s_cmd", {s_read, s_write, s_burstcount, s_byteenable, s_address}, exp_cmd);
        chk("s_writedata", s_writedata, exp_wd);
        chk("m_waitrequest", m_waitrequest, exp_wait);
        chk("m_readdatavalid", m_readdatavalid, exp_rdv);
        chk("m_readdata", m_readdata, s_readdata);
        if (s_write && !s_waitrequest) wlog.push_back(s_address);
        if (m_readdatavalid != '0) rlog.push_back({m_readdatavalid, m_readdata});
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic set_m(input int m, input bit rd, input bit wr, input logic [AW-1:0] a, input int bc);
        m_read[m]  = rd;
        m_write[m] = wr;
        m_address[m*AW +: AW]    = a;
        m_burstcount[m*BW +: BW] = BW'(bc);
        m_byteenable[m*4 +: 4]   = 4'hF;
        m_writedata[m*DW +: DW]  = {20'h0, a};
    endtask

    task automatic clr_all();
        m_read = '0; m_write = '0; m_address = '0; m_writedata = '0;
        m_byteenable = '0; m_burstcount = '0;
    endtask

    task automatic master_write(input int m, input logic [AW-1:0] a, input int bc);
        int need;
        int got;
        int guard;
        bit acc;
        need = (bc == 0) ? 1 : bc;
        got = 0;
        guard = 0;
        set_m(m, 0, 1, a, bc);
        while (got < need && guard < 100) begin
            @(negedge clock); acc = !m_waitrequest[m];
            @(posedge clock); #1;
            if (acc) begin
                got++;
                m_writedata[m*DW +: DW] = m_writedata[m*DW +: DW] + 1;
            end
            guard++;
        end
        m_write[m] = 1'b0;
        chk("write_beats_done", got, need);
    endtask

    task automatic master_read(input int m, input logic [AW-1:0] a, input int bc);
        int guard;
        bit acc;
        guard = 0;
        acc = 1'b0;
        set_m(m, 1, 0, a, bc);
        while (!acc && guard < 100) begin
            @(negedge clock); acc = !m_waitrequest[m];
            @(posedge clock); #1;
            guard++;
        end
        m_read[m] = 1'b0;
        last_rd_cyc = cyc;
        chk("read_cmd_done", acc, 1);
    endtask

    task automatic slave_resp(input logic [DW-1:0] d);
        s_readdatavalid = 1'b1;
        s_readdata      = d;
        step(1);
        s_readdatavalid = 1'b0;
        s_readdata      = '0;
    endtask

`ifdef AVMM_ARB_FIXED_PRIORITY_EN
    localparam logic [AW-1:0] T8_SECOND = 12'h401;
`else
    localparam logic [AW-1:0] T8_SECOND = 12'h500;
`endif

    initial begin
        int  g;
        bit  acc;
        int  resp_cyc;
        clr_all();
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        step(2);
        chk("rst_waitreq", m_waitrequest, 2'b11);
        chk("rst_s_rw", {s_read, s_write}, 2'b00);
        chk("rst_s_addr", s_address, 0);
        chk("rst_rdv", m_readdatavalid, 0);
        reset = 1'b0;
        step(1);

        // Simultaneous single writes: M0 first, M1 after a bubble.
        wlog.delete();
        fork
            master_write(0, 12'h010, 1);
            master_write(1, 12'h020, 1);
        join
        chk("t1_n", wlog.size(), 2);
        chk("t1_first", wlog[0], 12'h010);
        chk("t1_second", wlog[1], 12'h020);

        // 4-beat burst with two stall cycles on beat 2, M1 waiting.
        wlog.delete();
        fork
            master_write(0, 12'h100, 4);
            begin step(1); master_write(1, 12'h200, 1); end
            begin
                g = 0;
                @(negedge clock);
                while (!s_write && g < 20) begin @(negedge clock); g++; end
                chk("t2_slave_write", s_write, 1);
                @(posedge clock); #1;
                s_waitrequest = 1'b1;
                step(2);
                s_waitrequest = 1'b0;
            end
        join
        chk("t2_n", wlog.size(), 5);
        chk("t2_beat4", wlog[3], 12'h100);
        chk("t2_m1", wlog[4], 12'h200);

        // Read routing: M1 burst 3 then M0 burst 1.
        rlog.delete();
        master_read(1, 12'h004, 3);
        master_read(0, 12'h008, 1);
        slave_resp(32'hAA); slave_resp(32'hBB); slave_resp(32'hCC); slave_resp(32'hDD);
        chk("t3_n", rlog.size(), 4);
        chk("t3_b0", rlog[0], {2'b10, 32'hAA});
        chk("t3_b2", rlog[2], {2'b10, 32'hCC});
        chk("t3_b3", rlog[3], {2'b01, 32'hDD});

        // Full route FIFO: 5th read blocked while a write proceeds.
        for (int i = 0; i < 4; i++) master_read(0, 12'h040 + 12'(i), 1);
        wlog.delete(); rlog.delete();
        resp_cyc = 0;
        fork
            master_read(1, 12'h050, 1);
            master_write(0, 12'h060, 1);
            begin step(8); slave_resp(32'h11); resp_cyc = cyc; end
        join
        chk("t4_write", wlog.size(), 1);
        chk("t4_read_after_resp", last_rd_cyc > resp_cyc, 1);
        slave_resp(32'h12); slave_resp(32'h13); slave_resp(32'h14); slave_resp(32'h15);
        chk("t4_n", rlog.size(), 5);
        chk("t4_last", rlog[4], {2'b10, 32'h15});

        // Reset during beat 2 of a 4-beat write, with a read outstanding.
        wlog.delete(); rlog.delete();
        master_read(1, 12'h070, 1);
        set_m(0, 0, 1, 12'h080, 4);
        g = 0; acc = 1'b0;
        while (!acc && g < 50) begin @(negedge clock); acc = !m_waitrequest[0]; g++; end
        chk("t5_beat1", acc, 1);
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_s_write", s_write, 0);
        chk("t5_rst_waitreq", m_waitrequest, 2'b11);
        clr_all();
        @(posedge clock); #1;
        reset = 1'b0;
        slave_resp(32'h77);
        chk("t5_rdv_dropped", rlog.size(), 0);
        master_write(1, 12'h090, 1);
        chk("t5_n", wlog.size(), 2);
        chk("t5_after_rst", wlog[1], 12'h090);

        // Burstcount 0 behaves as a single beat.
        wlog.delete();
        fork
            master_write(0, 12'h0A0, 0);
            begin step(1); master_write(1, 12'h0B0, 1); end
        join
        chk("t6_n", wlog.size(), 2);
        chk("t6_m1", wlog[1], 12'h0B0);

        // Granted master drops its request: grant is held.
        wlog.delete();
        fork
            begin
                set_m(0, 0, 1, 12'h300, 1);
                step(1);
                m_write[0] = 1'b0;
                step(3);
                master_write(0, 12'h300, 1);
            end
            begin step(1); master_write(1, 12'h310, 1); end
        join
        chk("t7_n", wlog.size(), 2);
        chk("t7_first", wlog[0], 12'h300);
        chk("t7_second", wlog[1], 12'h310);

        // M0 requests back-to-back alongside M1.
        wlog.delete();
        fork
            begin
                for (int i = 0; i < 3; i++) master_write(0, 12'h400 + 12'(i), 1);
            end
            begin step(1); master_write(1, 12'h500, 1); end
        join
        chk("t8_n", wlog.size(), 4);
        chk("t8_second", wlog[1], T8_SECOND);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
